// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the requesters, the UART transmitter and the
// round-robin scheduler. The scheduler connects through the slave modport;
// the requester/transmitter side (or a bench) uses the master modport.
interface uart_tx_scheduler_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
);
  logic [NumReq-1:0]           Req;
  logic [NumReq*DataWidth-1:0] ReqData;
  logic [NumReq-1:0]           Ack;
  logic                        TxStart;
  logic [DataWidth-1:0]        TxData;
  logic                        TxBusy;
  logic                        TxDone;
  logic [$clog2(NumReq)-1:0]   Owner;
  logic                        Active;
  logic                        Timeout;

  modport master (
    output Req, ReqData, TxBusy, TxDone,
    input  Ack, TxStart, TxData, Owner, Active, Timeout
  );

  modport slave (
    input  Req, ReqData, TxBusy, TxDone,
    output Ack, TxStart, TxData, Owner, Active, Timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NumReq
// requesters. A grant lasts for up to MaxBurst bytes, then rotates to the
// next requester with a pending byte, searching cyclically after the last
// grant holder. Defining UART_TX_SCHEDULER_WATCHDOG_EN adds a watchdog that
// abandons a frame whose TxDone never arrives and raises a sticky Timeout.
module uart_tx_scheduler #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 8,
  parameter int MaxBurst      = 4,
  parameter int TimeoutCycles = 65535
) (
  input logic                Clock,
  input logic                Reset,
  uart_tx_scheduler_if.slave bus
);

  localparam int                OwnerW   = $clog2(NumReq);
  localparam logic [OwnerW-1:0] LastInit = OwnerW'(NumReq - 1);
  localparam logic [3:0]        BurstMax = 4'(MaxBurst);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [OwnerW-1:0]      owner_q, owner_d;
  logic [OwnerW-1:0]      last_q, last_d;
  logic [3:0]             burstCnt_q, burstCnt_d;
  logic                   active_q, active_d;
  logic [NumReq-1:0]      ack_q, ack_d;
  logic                   txStart_q, txStart_d;
  logic [DataWidth-1:0]   txData_q, txData_d;

`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
  localparam logic [15:0] WdLimit = 16'(TimeoutCycles - 1);
  logic                   timeout_q, timeout_d;
  logic [15:0]            wdCnt_q, wdCnt_d;
`endif

  logic                   found;
  logic [OwnerW-1:0]      pick;
  int                     idx;

  // Cyclic priority search: first pending requester after the last holder.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(last_q) + i) % NumReq;
      if (!found && bus.Req[idx]) begin
        found = 1'b1;
        pick  = OwnerW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    burstCnt_d = burstCnt_q;
    active_d   = active_q;
    ack_d      = '0;
    txStart_d  = 1'b0;
    txData_d   = txData_q;
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
    timeout_d  = timeout_q;
    wdCnt_d    = wdCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = pick;
          active_d   = 1'b1;
          burstCnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.Req[owner_q]) begin
          last_d   = owner_q;
          active_d = 1'b0;
          state_d  = IDLE;
        end else if (!bus.TxBusy) begin
          txStart_d      = 1'b1;
          ack_d[owner_q] = 1'b1;
          txData_d       = bus.ReqData[int'(owner_q)*DataWidth +: DataWidth];
          if (burstCnt_q != 4'hF) begin
            burstCnt_d = burstCnt_q + 4'd1;
          end
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
          wdCnt_d = '0;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.TxDone) begin
          if (bus.Req[owner_q] && (burstCnt_q < BurstMax)) begin
            state_d = ISSUE;
          end else begin
            last_d   = owner_q;
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
        else if (wdCnt_q == WdLimit) begin
          timeout_d = 1'b1;
          last_d    = owner_q;
          active_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          wdCnt_d = wdCnt_q + 16'd1;
        end
`endif
      end
      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= LastInit;
      burstCnt_q <= '0;
      active_q   <= 1'b0;
      ack_q      <= '0;
      txStart_q  <= 1'b0;
      txData_q   <= '0;
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
      timeout_q  <= 1'b0;
      wdCnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      burstCnt_q <= burstCnt_d;
      active_q   <= active_d;
      ack_q      <= ack_d;
      txStart_q  <= txStart_d;
      txData_q   <= txData_d;
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
      timeout_q  <= timeout_d;
      wdCnt_q    <= wdCnt_d;
`endif
    end
  end

  assign bus.Ack     = ack_q;
  assign bus.TxStart = txStart_q;
  assign bus.TxData  = txData_q;
  assign bus.Owner   = owner_q;
  assign bus.Active  = active_q;
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
  assign bus.Timeout = timeout_q;
`else
  assign bus.Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed checks of latency, TxBusy stall,
// withdrawal, rotation, watchdog (when UART_TX_SCHEDULER_WATCHDOG_EN is
// defined) and reset, then randomized rounds where every requester is
// loaded with a queue of bytes and the transmit order is predicted from
// the round-robin/burst rules alone.
module tb_uart_tx_scheduler;

  localparam int NumReq        = 4;
  localparam int DataWidth     = 8;
  localparam int MaxBurst      = 4;
  localparam int TimeoutCycles = 100;

  logic clock = 1'b0;
  logic resetN;

  always #5 clock = ~clock;

  uart_tx_scheduler_if #(.NumReq(NumReq), .DataWidth(DataWidth)) bus();

  uart_tx_scheduler #(
    .NumReq(NumReq),
    .DataWidth(DataWidth),
    .MaxBurst(MaxBurst),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .Clock(clock),
    .Reset(resetN),
    .bus(bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  qData[NumReq][$];
  int          expOwner[$];
  logic [7:0]  expData[$];
  int          expIdx    = 0;
  int          modelLast = NumReq - 1;
  bit          autoMode  = 1'b0;
  bit          randDelay = 1'b0;
  int          txTimer   = 0;
  int          txDelay   = 20;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drives the requester-side request vector and packed bytes.
  task automatic applyStimulus(input logic [NumReq-1:0] req, input logic [NumReq*DataWidth-1:0] data);
    bus.Req     = req;
    bus.ReqData = data;
  endtask

  // Presents the head of every non-empty queue as a pending request.
  task automatic refreshReq();
    logic [NumReq-1:0]           r;
    logic [NumReq*DataWidth-1:0] d;
    r = '0;
    d = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (qData[i].size() > 0) begin
        r[i] = 1'b1;
        d[i*DataWidth +: DataWidth] = qData[i][0];
      end
    end
    applyStimulus(r, d);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseDone();
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
  endtask

  // Reference order: serve the first non-empty queue after the last holder,
  // taking at most MaxBurst bytes from it before moving on.
  task automatic buildExpected();
    int len[NumReq];
    int pos[NumReq];
    int left;
    int last;
    expOwner.delete();
    expData.delete();
    left = 0;
    last = modelLast;
    for (int i = 0; i < NumReq; i++) begin
      len[i] = qData[i].size();
      pos[i] = 0;
      left  += len[i];
    end
    while (left > 0) begin
      for (int k = 1; k <= NumReq; k++) begin
        int c;
        c = (last + k) % NumReq;
        if (pos[c] < len[c]) begin
          for (int n = 0; n < MaxBurst && pos[c] < len[c]; n++) begin
            expOwner.push_back(c);
            expData.push_back(qData[c][pos[c]]);
            pos[c]++;
            left--;
          end
          last = c;
          break;
        end
      end
    end
  endtask

  // Requester and transmitter models, active only during automatic rounds.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (autoMode) begin
        if (bus.TxStart) begin
          if (expIdx < expOwner.size()) begin
            checkOutput("burst_owner", 32'(bus.Owner), 32'(expOwner[expIdx]));
            checkOutput("burst_data", 32'(bus.TxData), 32'(expData[expIdx]));
            checkOutput("burst_ack", 32'(bus.Ack), 32'd1 << expOwner[expIdx]);
          end else begin
            checkOutput("extra_start", 32'(bus.TxStart), 32'd0);
          end
          expIdx++;
          bus.TxBusy = 1'b1;
          txTimer = randDelay ? int'($urandom_range(2, 15)) : txDelay;
        end else if (bus.TxDone) begin
          bus.TxDone = 1'b0;
          bus.TxBusy = 1'b0;
        end else if (txTimer > 0) begin
          txTimer--;
          if (txTimer == 0) bus.TxDone = 1'b1;
        end
        for (int i = 0; i < NumReq; i++) begin
          if (bus.Ack[i] && qData[i].size() > 0) void'(qData[i].pop_front());
        end
        refreshReq();
      end
    end
  end

  // One automatic round: load queues, predict order, drain, compare.
  task automatic runRound(input bit fixedPattern);
    int cycles;
    int sum;
    sum = 0;
    for (int i = 0; i < NumReq; i++) begin
      qData[i].delete();
      if (fixedPattern) begin
        for (int n = 0; n < 4; n++) qData[i].push_back(8'(8'h10 + i));
      end else begin
        int l;
        l = int'($urandom_range(0, 6));
        for (int n = 0; n < l; n++) qData[i].push_back(8'($urandom));
      end
      sum += qData[i].size();
    end
    if (sum == 0) qData[0].push_back(8'($urandom));
    buildExpected();
    expIdx   = 0;
    txTimer  = 0;
    bus.TxBusy = 1'b0;
    bus.TxDone = 1'b0;
    @(negedge clock);
    refreshReq();
    autoMode = 1'b1;
    cycles   = 0;
    while (!(expIdx == expOwner.size() && txTimer == 0 && !bus.TxDone && !bus.Active) && cycles < 4000) begin
      @(negedge clock);
      cycles++;
    end
    autoMode = 1'b0;
    checkOutput("round_count", 32'(expIdx), 32'(expOwner.size()));
    checkOutput("round_in_time", 32'(cycles < 4000), 32'd1);
    if (expOwner.size() > 0) modelLast = expOwner[expOwner.size()-1];
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit sawStart;
    resetN = 1'b0;
    bus.TxBusy = 1'b0;
    bus.TxDone = 1'b0;
    applyStimulus('0, '0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_ack", 32'(bus.Ack), 32'd0);
    checkOutput("rst_start", 32'(bus.TxStart), 32'd0);
    checkOutput("rst_owner", 32'(bus.Owner), 32'd0);
    checkOutput("rst_active", 32'(bus.Active), 32'd0);
    checkOutput("rst_timeout", 32'(bus.Timeout), 32'd0);
    resetN = 1'b1;
    tick();

    // Single byte: two-edge latency to TxStart/Ack.
    applyStimulus(4'b0001, 32'h0000_0055);
    tick();
    checkOutput("lat_start_early", 32'(bus.TxStart), 32'd0);
    checkOutput("lat_active", 32'(bus.Active), 32'd1);
    tick();
    checkOutput("lat_start", 32'(bus.TxStart), 32'd1);
    checkOutput("lat_ack", 32'(bus.Ack), 32'b0001);
    checkOutput("lat_data", 32'(bus.TxData), 32'h55);
    checkOutput("lat_owner", 32'(bus.Owner), 32'd0);
    applyStimulus('0, '0);
    tick();
    checkOutput("pulse_width", 32'(bus.TxStart), 32'd0);
    checkOutput("ack_width", 32'(bus.Ack), 32'd0);
    pulseDone();
    checkOutput("single_release", 32'(bus.Active), 32'd0);

    // TxBusy held while ISSUE waits.
    bus.TxBusy = 1'b1;
    applyStimulus(4'b0100, 32'h00A7_0000);
    tick();
    checkOutput("busy_owner", 32'(bus.Owner), 32'd2);
    sawStart = 1'b0;
    repeat (10) begin
      tick();
      sawStart |= bus.TxStart;
    end
    checkOutput("busy_no_start", 32'(sawStart), 32'd0);
    bus.TxBusy = 1'b0;
    tick();
    checkOutput("busy_start", 32'(bus.TxStart), 32'd1);
    checkOutput("busy_data", 32'(bus.TxData), 32'hA7);
    applyStimulus('0, '0);
    pulseDone();

    // Withdrawal in ISSUE, then rotation from Last=1.
    bus.TxBusy = 1'b1;
    applyStimulus(4'b0010, 32'h0000_3C00);
    tick();
    checkOutput("wd_owner", 32'(bus.Owner), 32'd1);
    applyStimulus('0, '0);
    tick();
    checkOutput("withdraw_idle", 32'(bus.Active), 32'd0);
    checkOutput("withdraw_ack", 32'(bus.Ack), 32'd0);
    bus.TxBusy = 1'b0;
    applyStimulus(4'b0110, 32'h0062_6100);
    tick();
    checkOutput("rot_first_owner", 32'(bus.Owner), 32'd2);
    tick();
    checkOutput("rot_first_ack", 32'(bus.Ack), 32'b0100);
    checkOutput("rot_first_data", 32'(bus.TxData), 32'h62);
    applyStimulus(4'b0010, 32'h0000_6100);
    pulseDone();
    tick();
    checkOutput("rot_second_owner", 32'(bus.Owner), 32'd1);
    tick();
    checkOutput("rot_second_ack", 32'(bus.Ack), 32'b0010);
    checkOutput("rot_second_data", 32'(bus.TxData), 32'h61);
    applyStimulus('0, '0);
    pulseDone();
    tick();

    // Missing TxDone.
    applyStimulus(4'b0001, 32'h0000_0077);
    tick();
    tick();
    checkOutput("wdog_ack", 32'(bus.Ack), 32'b0001);
    applyStimulus('0, '0);
`ifdef UART_TX_SCHEDULER_WATCHDOG_EN
    repeat (TimeoutCycles - 1) tick();
    checkOutput("wdog_not_yet", 32'(bus.Timeout), 32'd0);
    tick();
    checkOutput("wdog_flag", 32'(bus.Timeout), 32'd1);
    checkOutput("wdog_active", 32'(bus.Active), 32'd0);
    applyStimulus(4'b0010, 32'h0000_8800);
    tick();
    tick();
    checkOutput("wdog_next_ack", 32'(bus.Ack), 32'b0010);
    checkOutput("wdog_sticky", 32'(bus.Timeout), 32'd1);
    applyStimulus('0, '0);
`else
    repeat (TimeoutCycles + 20) tick();
    checkOutput("nowdog_active", 32'(bus.Active), 32'd1);
    checkOutput("nowdog_timeout", 32'(bus.Timeout), 32'd0);
`endif

    // Reset while in WAIT.
    tick();
    resetN = 1'b0;
    #1;
    checkOutput("midrst_active", 32'(bus.Active), 32'd0);
    checkOutput("midrst_data", 32'(bus.TxData), 32'd0);
    checkOutput("midrst_owner", 32'(bus.Owner), 32'd0);
    checkOutput("midrst_timeout", 32'(bus.Timeout), 32'd0);
    tick();
    applyStimulus(4'b1001, 32'h9900_0011);
    resetN = 1'b1;
    tick();
    checkOutput("postrst_owner", 32'(bus.Owner), 32'd0);
    tick();
    checkOutput("postrst_ack", 32'(bus.Ack), 32'b0001);
    applyStimulus('0, '0);

    // Fresh start for the model-driven rounds.
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    modelLast = NumReq - 1;
    tick();
    randDelay = 1'b0;
    txDelay   = 20;
    runRound(1'b1);
    randDelay = 1'b1;
    for (int r = 0; r < 6; r++) runRound(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
